// File: rtl/omp_iter_sequencer.sv
// omp_iter_sequencer
// Iteration controller for the OMP recovery datapath. Each iteration it sweeps
// every dictionary atom through the correlator, keeps the largest-magnitude
// correlation among atoms not yet in the support, records the winner in the
// support bitmap and hands off to the residual-update stage. After K_ITER
// iterations it pulses done. All control outputs are decoded from the state.

module omp_iter_sequencer #(
   parameter int N_ATOMS = 64,
   parameter int ADDR_W  = 6,
   parameter int K_ITER  = 4,
   parameter int CORR_W  = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   output logic                     ram_en,
   output logic [ADDR_W-1:0]        ram_addr,
   input  logic                     corr_valid,
   input  logic signed [CORR_W-1:0] corr_val,
   output logic                     sel_valid,
   output logic [ADDR_W-1:0]        sel_idx,
   output logic                     upd_start,
   input  logic                     upd_done,
   output logic                     busy,
   output logic                     done,
   output logic [N_ATOMS-1:0]       output_bits
);

   // Return counter needs one extra bit so it can hold N_ATOMS itself.
   localparam int CNT_W  = ADDR_W + 1;
   localparam int ITER_W = $clog2(K_ITER + 1);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ATOMS - 1);
   localparam logic [CNT_W-1:0]  N_RET     = CNT_W'(N_ATOMS);
   localparam logic [ITER_W-1:0] K_LAST    = ITER_W'(K_ITER);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SWEEP  = 3'd1,
      S_SCAN   = 3'd2,
      S_SELECT = 3'd3,
      S_UPDATE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic [ADDR_W-1:0]  addr_reg;
   logic [CNT_W-1:0]   ret_cnt_reg;
   logic [ITER_W-1:0]  iter_reg;
   logic [ADDR_W-1:0]  best_idx_reg;
   logic [CORR_W-1:0]  best_mag_reg;
   logic               best_vld_reg;
   logic [ADDR_W-1:0]  sel_idx_reg;
   logic [N_ATOMS-1:0] bits_reg;

   // Decoded control events shared by the datapath registers.
   logic              run_accept;
   logic              enter_sweep;
   logic              enter_select;
   logic              upd_ack;
   logic              ret_accept;
   logic              ret_eligible;
   logic              take_best;
   logic [ADDR_W-1:0] ret_idx;
   logic [CORR_W-1:0] corr_mag;

   // Next-state logic; abort overrides every transition outside IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (start) state_next = S_SWEEP;
         S_SWEEP:  if (addr_reg == LAST_ADDR) state_next = S_SCAN;
         S_SCAN:   if (ret_cnt_reg == N_RET) state_next = S_SELECT;
         S_SELECT: state_next = S_UPDATE;
         S_UPDATE: begin
            if (upd_done) begin
               if (iter_reg + ITER_W'(1) == K_LAST) state_next = S_DONE;
               else                                 state_next = S_SWEEP;
            end
         end
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
      if (abort && (state_reg != S_IDLE)) state_next = S_IDLE;
   end

   // Event decode and magnitude compare for the incoming correlation.
   always_comb begin
      run_accept   = (state_reg == S_IDLE) && start;
      enter_sweep  = (state_next == S_SWEEP) && (state_reg != S_SWEEP);
      enter_select = (state_next == S_SELECT) && (state_reg == S_SCAN);
      upd_ack      = (state_reg == S_UPDATE) && upd_done && !abort;
      ret_idx      = ret_cnt_reg[ADDR_W-1:0];
      // Two's-complement negate: the most negative value maps to 2^(CORR_W-1)
      // exactly, which still fits as an unsigned CORR_W-bit magnitude.
      corr_mag     = corr_val[CORR_W-1] ? $unsigned(-corr_val) : $unsigned(corr_val);
      ret_accept   = corr_valid
                     && ((state_reg == S_SWEEP) || (state_reg == S_SCAN))
                     && (ret_cnt_reg != N_RET);
      ret_eligible = !bits_reg[ret_idx];
      // Strict compare keeps the lower index on ties; the first eligible
      // atom is always taken so a zero-magnitude winner still exists.
      take_best    = ret_accept && ret_eligible
                     && (!best_vld_reg || (corr_mag > best_mag_reg));
   end

   // Moore outputs decoded from the state register.
   always_comb begin
      ram_en      = (state_reg == S_SWEEP);
      ram_addr    = addr_reg;
      sel_valid   = (state_reg == S_SELECT);
      upd_start   = (state_reg == S_SELECT);
      busy        = (state_reg == S_SWEEP) || (state_reg == S_SCAN)
                    || (state_reg == S_SELECT) || (state_reg == S_UPDATE);
      done        = (state_reg == S_DONE);
      sel_idx     = sel_idx_reg;
      output_bits = bits_reg;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // Read address walks 0..N_ATOMS-1 while sweeping and parks at zero otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg <= '0;
      end else if ((state_reg == S_SWEEP) && (state_next == S_SWEEP)) begin
         addr_reg <= addr_reg + ADDR_W'(1);
      end else begin
         addr_reg <= '0;
      end
   end

   // Return counter and running best; cleared at the start of every sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ret_cnt_reg  <= '0;
         best_idx_reg <= '0;
         best_mag_reg <= '0;
         best_vld_reg <= 1'b0;
      end else if (enter_sweep) begin
         ret_cnt_reg  <= '0;
         best_idx_reg <= '0;
         best_mag_reg <= '0;
         best_vld_reg <= 1'b0;
      end else if (ret_accept) begin
         ret_cnt_reg <= ret_cnt_reg + CNT_W'(1);
         if (take_best) begin
            best_idx_reg <= ret_idx;
            best_mag_reg <= corr_mag;
            best_vld_reg <= 1'b1;
         end
      end
   end

   // Iteration counter: zeroed on an accepted start, advanced per update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          iter_reg <= '0;
      else if (run_accept) iter_reg <= '0;
      else if (upd_ack)    iter_reg <= iter_reg + ITER_W'(1);
   end

   // Chosen index is latched on entry to SELECT and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            sel_idx_reg <= '0;
      else if (enter_select) sel_idx_reg <= best_idx_reg;
   end

   // Support bitmap, one flop per atom: cleared on start, set when selected.
   generate
      for (genvar gi = 0; gi < N_ATOMS; gi++) begin : g_support
         logic bit_reg;

         // Per-atom support flag.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               bit_reg <= 1'b0;
            else if (run_accept)
               bit_reg <= 1'b0;
            else if (enter_select && (best_idx_reg == ADDR_W'(gi)))
               bit_reg <= 1'b1;
         end

         assign bits_reg[gi] = bit_reg;
      end
   endgenerate

endmodule

// File: tb/tb_omp_iter_sequencer.sv
// tb_omp_iter_sequencer
// Directed bench: a correlator model with programmable latency answers RAM
// reads from a correlation table, an update-stage model answers upd_start,
// and a scoreboard queue holds the atom indices each run must select.

module tb_omp_iter_sequencer;

   localparam int N  = 64;
   localparam int AW = 6;
   localparam int K  = 4;
   localparam int CW = 24;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic                 start = 1'b0;
   logic                 abort = 1'b0;
   logic                 ram_en;
   logic [AW-1:0]        ram_addr;
   logic                 corr_valid = 1'b0;
   logic signed [CW-1:0] corr_val = '0;
   logic                 sel_valid;
   logic [AW-1:0]        sel_idx;
   logic                 upd_start;
   logic                 upd_done = 1'b0;
   logic                 busy;
   logic                 done;
   logic [N-1:0]         output_bits;

   int n_cmp = 0;
   int n_mis = 0;

   // Scoreboard and event counters kept by the monitor.
   int exp_q[$];
   int exp_sel;
   int en_cnt = 0;
   int en_total = 0;
   bit addr_ok = 1'b1;
   int sel_cnt = 0;
   int done_cnt = 0;

   // Environment models.
   logic signed [CW-1:0] tab [N];
   logic [AW:0]          pipe [0:7] = '{default: '0};
   int                   lat = 3;
   int                   upd_cnt = 0;
   bit                   upd_auto = 1'b1;
   bit                   upd_kick = 1'b0;

   omp_iter_sequencer #(
      .N_ATOMS (N),
      .ADDR_W  (AW),
      .K_ITER  (K),
      .CORR_W  (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .ram_en      (ram_en),
      .ram_addr    (ram_addr),
      .corr_valid  (corr_valid),
      .corr_val    (corr_val),
      .sel_valid   (sel_valid),
      .sel_idx     (sel_idx),
      .upd_start   (upd_start),
      .upd_done    (upd_done),
      .busy        (busy),
      .done        (done),
      .output_bits (output_bits)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Correlator and update-stage models, driven away from the active edge.
   always @(negedge clk) begin
      for (int i = 7; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0]    = {ram_en, ram_addr};
      corr_valid = pipe[lat][AW];
      corr_val   = tab[pipe[lat][AW-1:0]];
      upd_done   = 1'b0;
      if (upd_cnt > 0) begin
         upd_cnt--;
         if (upd_cnt == 0) upd_done = 1'b1;
      end
      if (upd_start && upd_auto) upd_cnt = 3;
      if (upd_kick) upd_done = 1'b1;
   end

   // Monitor: address order, reads per iteration, scoreboard pops.
   always @(negedge clk) begin
      if (ram_en === 1'b1) begin
         if (ram_addr !== en_cnt[AW-1:0]) addr_ok = 1'b0;
         en_cnt++;
         en_total++;
      end
      if (sel_valid === 1'b1) begin
         sel_cnt++;
         check("sel_pending", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            exp_sel = exp_q.pop_front();
            check("sel_idx", 64'(sel_idx), 64'(exp_sel));
            $display("sel #%0d: idx=%0d expected=%0d reads=%0d", sel_cnt, sel_idx, exp_sel, en_cnt);
         end
         check("sel_reads_per_iter", 64'(en_cnt), 64'(N));
         check("sel_addr_order", 64'(addr_ok), 64'd1);
         check("sel_bit_set", 64'(output_bits[sel_idx]), 64'd1);
         en_cnt  = 0;
         addr_ok = 1'b1;
      end
      if (done === 1'b1) begin
         done_cnt++;
         $display("done #%0d: output_bits=%h", done_cnt, output_bits);
      end
      if (busy !== 1'b1) begin
         en_cnt  = 0;
         addr_ok = 1'b1;
      end
   end

   task automatic pulse_start(input bit with_abort);
      @(negedge clk);
      start = 1'b1;
      abort = with_abort;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic clear_tab();
      for (int i = 0; i < N; i++) tab[i] = '0;
   endtask

   task automatic peak_tab();
      for (int i = 0; i < N; i++) tab[i] = CW'((i % 5) - 2);
      tab[5]  = 24'sd1000;
      tab[40] = 24'sd900;
      tab[63] = -24'sd800;
      tab[12] = 24'sd700;
   endtask

   // One full run: expected picks queued up front, checked as they appear.
   task automatic do_run(input string tag, input int l, input int e0, input int e1,
                         input int e2, input int e3, input bit with_abort, input bit poke);
      logic [N-1:0] mask;
      int d0, s0, t0;
      bit seen;
      mask = '0;
      mask[e0] = 1'b1;
      mask[e1] = 1'b1;
      mask[e2] = 1'b1;
      mask[e3] = 1'b1;
      lat = l;
      exp_q.push_back(e0);
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      exp_q.push_back(e3);
      d0 = done_cnt;
      s0 = sel_cnt;
      t0 = en_total;
      pulse_start(with_abort);
      if (poke) begin
         repeat (10) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      seen = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (poke) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      repeat (5) @(negedge clk);
      check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
      check({tag, "_sel_count"}, 64'(sel_cnt - s0), 64'(K));
      check({tag, "_bitmap"}, 64'(output_bits), 64'(mask));
      check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_ram_reads"}, 64'(en_total - t0), 64'(N * K));
      check({tag, "_idle"}, 64'({busy, ram_en}), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, s0;
      bit seen;
      clear_tab();

      // Power-on reset values.
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", 64'({ram_en, ram_addr, sel_valid, sel_idx, upd_start, busy, done}), 64'd0);
      check("reset_bits", 64'(output_bits), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // T2: four peaks, latency 3.
      peak_tab();
      do_run("t2", 3, 5, 40, 63, 12, 1'b0, 1'b0);

      // T1: asynchronous reset in the middle of a sweep.
      pulse_start(1'b0);
      repeat (20) @(negedge clk);
      check("t1_sweeping", 64'({busy, ram_en}), 64'h3);
      #2 rst_n = 1'b0;
      #1;
      check("t1_async_ctrl", 64'({ram_en, ram_addr, sel_valid, sel_idx, upd_start, busy, done}), 64'd0);
      check("t1_async_bits", 64'(output_bits), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("t1_idle_after", 64'({busy, ram_en}), 64'd0);

      // T3: tie keeps lower index, then all-zero picks lowest unselected.
      clear_tab();
      tab[7] = 24'sd100;
      tab[9] = 24'sd100;
      do_run("t3", 1, 7, 9, 0, 1, 1'b0, 1'b0);

      // T4: reselect guard, then an all-zero table.
      clear_tab();
      tab[3]  = 24'sd5000;
      tab[50] = 24'sd300;
      do_run("t4a", 5, 3, 50, 0, 1, 1'b0, 1'b0);
      clear_tab();
      do_run("t4b", 4, 0, 1, 2, 3, 1'b0, 1'b0);

      // T5: most negative value outranks most positive; start+abort in IDLE.
      clear_tab();
      tab[20] = -24'sh800000;
      tab[21] = 24'sh7FFFFF;
      do_run("t5", 2, 20, 21, 0, 1, 1'b1, 1'b0);

      // T6a: start while busy and in DONE is ignored.
      peak_tab();
      do_run("t6a", 3, 5, 40, 63, 12, 1'b0, 1'b1);

      // T6b: abort during UPDATE, late upd_done ignored.
      upd_auto = 1'b0;
      lat = 3;
      exp_q.push_back(5);
      d0 = done_cnt;
      s0 = sel_cnt;
      pulse_start(1'b0);
      seen = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (upd_start === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check("t6b_upd_start_seen", 64'(seen), 64'd1);
      @(negedge clk);
      check("t6b_in_update", 64'({busy, ram_en}), 64'h2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t6b_abort_idle", 64'({busy, ram_en, sel_valid, upd_start, done}), 64'd0);
      @(negedge clk);
      #2 upd_kick = 1'b1;
      @(negedge clk);
      #2 upd_kick = 1'b0;
      repeat (10) @(negedge clk);
      check("t6b_still_idle", 64'({busy, ram_en}), 64'd0);
      check("t6b_no_done", 64'(done_cnt - d0), 64'd0);
      check("t6b_one_sel", 64'(sel_cnt - s0), 64'd1);
      check("t6b_partial_bits", 64'(output_bits), 64'h20);
      check("t6b_sel_held", 64'(sel_idx), 64'd5);
      check("t6b_queue_empty", 64'(exp_q.size()), 64'd0);
      upd_auto = 1'b1;
      exp_q.delete();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
